// File: rtl/mxv_pkg.sv
// Shared byte width, frame delimiters, command codes and parser state encoding
// for the UART-to-matrix-core receive path.
package mxv_pkg;

  localparam int unsigned DW = 8;

  localparam logic [DW-1:0] SOF_BYTE = 8'hFE;
  localparam logic [DW-1:0] EOF_BYTE = 8'hEF;

  typedef enum logic [2:0] {
    CMD_SET_N    = 3'd1,
    CMD_RESEND   = 3'd2,
    CMD_START    = 3'd3,
    CMD_LOAD_MAT = 3'd4,
    CMD_LOAD_VEC = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_CMD,
    ST_DATA,
    ST_EOF,
    ST_ISSUE,
    ST_DRAIN
  } parser_state_e;

  function automatic logic cmd_legal(input logic [DW-1:0] b);
    return (b >= DW'(CMD_SET_N)) && (b <= DW'(CMD_LOAD_VEC));
  endfunction

endpackage

// File: rtl/mxv_payload_buf.sv
// Payload holding buffer: registered write port, combinational read port,
// synchronous whole-buffer clear.
module mxv_payload_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mxv_rx_frame_parser.sv
// Validates FE|LEN|CMD|PAYLOAD|EF frames byte by byte, then releases a command
// pulse followed by the buffered payload; bad frames are dropped and flagged.
module mxv_rx_frame_parser
  import mxv_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 16,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  input  logic          fifo_full,
  output logic          cmd_valid,
  output logic [2:0]    cmd_code,
  output logic          data_valid,
  output logic [DW-1:0] data_out,
  output logic          frame_err,
  output logic          busy
);

  localparam int unsigned   PW      = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned   AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DW-1:0] LEN_MAX = DW'(MAX_PAYLOAD + 1);

  parser_state_e state;
  logic [PW-1:0] remaining;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    cmd_lat;
  logic          buf_wr_en;
  logic          buf_clr;
  logic [DW-1:0] buf_rd_data;

  assign buf_wr_en = (state == ST_DATA) && rx_valid;
  assign buf_clr   = (state == ST_EOF) && rx_valid && (rx_data != EOF_BYTE);
  assign busy      = (state != ST_IDLE);

  mxv_payload_buf #(
    .DW    (DW),
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr_en),
    .wr_ptr  (wr_ptr[AW-1:0]),
    .wr_data (rx_data),
    .rd_ptr  (rd_ptr[AW-1:0]),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tmo_cnt    <= '0;
      cmd_lat    <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      frame_err  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (rx_valid && (rx_data == SOF_BYTE)) state <= ST_LEN;
        end

        ST_LEN, ST_CMD, ST_DATA, ST_EOF: begin
          if (rx_valid) begin
            tmo_cnt <= '0;
            case (state)
              ST_LEN: begin
                if ((rx_data != '0) && (rx_data <= LEN_MAX)) begin
                  remaining <= PW'(rx_data - DW'(1));
                  state     <= ST_CMD;
                end else begin
                  frame_err <= 1'b1;
                  state     <= ST_IDLE;
                end
              end
              ST_CMD: begin
                if (cmd_legal(rx_data)) begin
                  cmd_lat <= rx_data[2:0];
                  state   <= (remaining != '0) ? ST_DATA : ST_EOF;
                end else begin
                  frame_err <= 1'b1;
                  state     <= ST_IDLE;
                end
              end
              ST_DATA: begin
                wr_ptr    <= wr_ptr + PW'(1);
                remaining <= remaining - PW'(1);
                if (remaining == PW'(1)) state <= ST_EOF;
              end
              ST_EOF: begin
                if (rx_data == EOF_BYTE) begin
                  cmd_valid <= 1'b1;
                  cmd_code  <= cmd_lat;
                  state     <= ST_ISSUE;
                end else begin
                  frame_err <= 1'b1;
                  wr_ptr    <= '0;
                  state     <= ST_IDLE;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            frame_err <= 1'b1;
            wr_ptr    <= '0;
            tmo_cnt   <= '0;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        // ISSUE already pushes byte 0 so the first data_valid lands directly
        // after cmd_valid; DRAIN continues from rd_ptr with the same logic.
        ST_ISSUE, ST_DRAIN: begin
          if (rx_valid) frame_err <= 1'b1;
          if (wr_ptr == '0) begin
            state <= ST_IDLE;
          end else if (!fifo_full) begin
            data_valid <= 1'b1;
            data_out   <= buf_rd_data;
            if (rd_ptr + PW'(1) == wr_ptr) begin
              rd_ptr <= '0;
              wr_ptr <= '0;
              state  <= ST_IDLE;
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
              state  <= ST_DRAIN;
            end
          end else begin
            state <= ST_DRAIN;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_rx_frame_parser.sv
// Directed frames with hand-computed expected events; a negedge monitor pops
// the scoreboard for every cmd/data/error pulse the parser emits.
module tb_mxv_rx_frame_parser;
  import mxv_pkg::*;

  localparam int unsigned TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       fifo_full = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       data_valid;
  logic [7:0] data_out;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  mxv_rx_frame_parser #(
    .MAX_PAYLOAD (16),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .fifo_full  (fifo_full),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .data_valid (data_valid),
    .data_out   (data_out),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef enum int {K_CMD, K_DATA, K_ERR} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void expect_ev(input kind_e k, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void pop_check(input kind_e k, input logic [7:0] v);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s %0h expected nothing", k.name(), v);
      return;
    end
    e = exp_q.pop_front();
    if ((e.kind != k) || ((k != K_ERR) && (e.val !== v))) begin
      errors++;
      $display("FAIL sb_event: got %s %0h expected %s %0h", k.name(), v, e.kind.name(), e.val);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid && frame_err) begin
        checks++;
        errors++;
        $display("FAIL cmd_err_excl: got cmd_valid=1 frame_err=1 expected not both");
      end
      if (cmd_valid)  pop_check(K_CMD, {5'd0, cmd_code});
      if (data_valid) pop_check(K_DATA, data_out);
      if (frame_err)  pop_check(K_ERR, 8'h00);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int  n;
    bit  done;
    n    = 0;
    done = (exp_q.size() == 0) && !busy;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: got pending=%0d busy=%0b expected idle within %0d cycles",
               name, exp_q.size(), busy, limit);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"},  cmd_valid,  0);
    check({tag, "_cmd_code"},   cmd_code,   0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_data_out"},   data_out,   0);
    check({tag, "_frame_err"},  frame_err,  0);
    check({tag, "_busy"},       busy,       0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b1;
    @(negedge clk);

    // Two-byte LOAD_MAT frame with exact latencies
    expect_ev(K_CMD, 8'h04);
    expect_ev(K_DATA, 8'h11);
    expect_ev(K_DATA, 8'h22);
    send_seq('{8'hFE, 8'h03, 8'h04, 8'h11, 8'h22});
    send(8'hEF);
    check("a_cmd_valid", cmd_valid, 1);
    check("a_cmd_code", cmd_code, 4);
    @(negedge clk);
    check("a_d0_valid", data_valid, 1);
    check("a_d0", data_out, 8'h11);
    @(negedge clk);
    check("a_d1_valid", data_valid, 1);
    check("a_d1", data_out, 8'h22);
    wait_idle(20, "a_idle");

    // Empty payload START
    expect_ev(K_CMD, 8'h03);
    send_seq('{8'hFE, 8'h01, 8'h03});
    send(8'hEF);
    check("b_cmd_valid", cmd_valid, 1);
    @(negedge clk);
    check("b_busy_low", busy, 0);
    check("b_no_data", data_valid, 0);
    wait_idle(20, "b_idle");

    // Bad EOF then a good RESEND
    send_seq('{8'hFE, 8'h02, 8'h05, 8'hAA});
    expect_ev(K_ERR, 8'h00);
    send(8'h55);
    check("c_err", frame_err, 1);
    check("c_no_cmd", cmd_valid, 0);
    wait_idle(20, "c_idle");
    expect_ev(K_CMD, 8'h02);
    send_seq('{8'hFE, 8'h01, 8'h02, 8'hEF});
    wait_idle(20, "c2_idle");

    // Stray bytes, LEN bounds, illegal command
    send_seq('{8'h33, 8'h33});
    send(8'hFE);
    expect_ev(K_ERR, 8'h00);
    send(8'h12);
    wait_idle(20, "d_len18");
    send(8'hFE);
    expect_ev(K_ERR, 8'h00);
    send(8'h00);
    wait_idle(20, "d_len0");
    send_seq('{8'hFE, 8'h01});
    expect_ev(K_ERR, 8'h00);
    send(8'h07);
    send(8'hEF);
    wait_idle(20, "d_cmd7");

    // Maximum payload: LEN=17, 16 bytes
    expect_ev(K_CMD, 8'h01);
    for (int i = 0; i < 16; i++) expect_ev(K_DATA, 8'(8'h80 + i));
    send_seq('{8'hFE, 8'h11, 8'h01});
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    send(8'hEF);
    wait_idle(40, "e_max");

    // FIFO full stalls the drain
    expect_ev(K_CMD, 8'h05);
    expect_ev(K_DATA, 8'h01);
    expect_ev(K_DATA, 8'h02);
    expect_ev(K_DATA, 8'h03);
    send_seq('{8'hFE, 8'h04, 8'h05, 8'h01, 8'h02, 8'h03});
    fifo_full = 1'b1;
    send(8'hEF);
    check("f_cmd_valid", cmd_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("f_stall", data_valid, 0);
    end
    fifo_full = 1'b0;
    wait_idle(20, "f_idle");

    // Overrun during drain: byte dropped, frame still delivered
    expect_ev(K_CMD, 8'h05);
    expect_ev(K_DATA, 8'h33);
    expect_ev(K_DATA, 8'h44);
    expect_ev(K_ERR, 8'h00);
    send_seq('{8'hFE, 8'h03, 8'h05, 8'h33, 8'h44, 8'hEF});
    send(8'hFE);
    wait_idle(20, "g_idle");

    // Inter-byte timeout lands exactly TMO cycles after the last byte
    expect_ev(K_ERR, 8'h00);
    send_seq('{8'hFE, 8'h02, 8'h04});
    n = 0;
    while (!frame_err && n < int'(TMO) + 10) begin
      @(negedge clk);
      n++;
    end
    check("h_tmo_cycles", n, TMO);
    @(negedge clk);
    check("h_busy", busy, 0);
    wait_idle(20, "h_idle");
    check("h_data_hold", data_out, 8'h44);

    // Reset mid-DATA then a clean frame
    send_seq('{8'hFE, 8'h05, 8'h04, 8'hAA});
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("i_rst");
    rst = 1'b1;
    @(negedge clk);
    expect_ev(K_CMD, 8'h01);
    expect_ev(K_DATA, 8'h99);
    send_seq('{8'hFE, 8'h02, 8'h01, 8'h99, 8'hEF});
    wait_idle(20, "i_idle");

    repeat (5) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
